seg_display_scan: RTL

//  Multiplexed 6-digit seven-segment driver for the HH:MM:SS clock.
//  - Consumes the six BCD digit buses from the clock counter and scans one digit at a time.
//  - Applies hour-tens leading-zero blanking, colon decimal points, and set-mode blinking.
//  - Drives the board's shared segment bus and per-digit enables.

---
 rtl/seg_display_scan.sv | 90 +++++++++
 1 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan: multiplexed 6-digit seven-segment driver with leading-zero blanking, colons and set-mode blink.
// Optional SCAN_DEADTIME_EN holds all digit enables off for DEAD_CYC cycles at each slot start.
module seg_display_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int DEAD_CYC  = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] q_hour_ten,
  input  logic [3:0] q_hour_one,
  input  logic [3:0] q_min_ten,
  input  logic [3:0] q_min_one,
  input  logic [3:0] q_sec_ten,
  input  logic [3:0] q_sec_one,
  input  logic       set_active,
  input  logic       set_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [SW-1:0] scan_cnt, scan_cnt_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic [2:0] idx, idx_n;
  logic [23:0] snap, snap_n;
  logic [3:0] val;
  logic tick, live, live_n, blink_ph, blink_ph_n, set_q, rise, bterm, blank, dead;
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction
  always_comb begin
    tick = scan_cnt == SW'(SCAN_DIV - 1);
    scan_cnt_n = tick ? '0 : scan_cnt + 1'b1;
    idx_n = tick ? (idx == 3'd5 ? 3'd0 : idx + 3'd1) : idx;
    snap_n = (tick && idx == 3'd5) ?
      {q_hour_ten, q_hour_one, q_min_ten, q_min_one, q_sec_ten, q_sec_one} : snap;
    live_n = live | tick;
    rise = set_active & ~set_q;
    bterm = blink_cnt == BW'(BLINK_DIV - 1);
    blink_cnt_n = (rise | bterm) ? '0 : blink_cnt + 1'b1;
    blink_ph_n = rise ? 1'b1 : bterm ? ~blink_ph : blink_ph;
    val = snap_n[{idx_n, 2'b00} +: 4];
    blank = (idx_n == 3'd5 && val == 4'd0) ||
      (set_active && !blink_ph_n && (set_sel ? idx_n >= 3'd4 : (idx_n == 3'd2 || idx_n == 3'd3)));
`ifdef SCAN_DEADTIME_EN
    dead = scan_cnt_n < SW'(DEAD_CYC);
`else
    dead = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      blink_cnt <= '0;
      idx       <= 3'd5;
      snap      <= '0;
      live      <= 1'b0;
      blink_ph  <= 1'b1;
      set_q     <= 1'b0;
      seg       <= 7'h7F;
      dp        <= 1'b1;
      an        <= 6'h3F;
    end else begin
      scan_cnt  <= scan_cnt_n;
      blink_cnt <= blink_cnt_n;
      idx       <= idx_n;
      snap      <= snap_n;
      live      <= live_n;
      blink_ph  <= blink_ph_n;
      set_q     <= set_active;
      seg       <= (live_n && !blank) ? dec(val) : 7'h7F;
      dp        <= !(live_n && !blank && (idx_n == 3'd2 || idx_n == 3'd4));
      an        <= (live_n && !dead) ? ~(6'b1 << idx_n) : 6'h3F;
    end
  end
endmodule
